// File: rtl/iter_alu_pkg.sv
// Shared types and constants for the iterative ARM-subset execution unit.
// Holds the opcode and FSM state encodings plus the flag bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_ORR = 4'b0011,
        OP_EOR = 4'b0100,
        OP_MOV = 4'b0101,
        OP_CMP = 4'b0110,
        OP_TST = 4'b0111,
        OP_MUL = 4'b1000,
        OP_MLA = 4'b1001
    } alu_op_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Raw opcode bits are compared so reserved codes never need an enum cast.
    function automatic logic isMulOp(input logic [3:0] opBits);
        return (opBits == OP_MUL) || (opBits == OP_MLA);
    endfunction

endpackage

// File: rtl/iter_alu_mul.sv
// Shift-add multiplier datapath: one multiplier bit is consumed per step.
// last_o flags the step whose result (acc_o) is the final product.
module iter_mul
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             mla_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic [WIDTH-1:0] acc_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] accStep;
    logic             countDone;
    logic             mplierDone;

    assign accStep    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign countDone  = (count_q == CW'(WIDTH - 1));
    // Looks at the multiplier as it will be after this step's shift.
    assign mplierDone = (mplier_q[WIDTH-1:1] == '0);

    assign acc_o  = accStep;
    assign last_o = countDone || ((EARLY_TERM != 0) && mplierDone);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = mla_i ? c_i : '0;
            count_d  = '0;
        end else if (step_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = accStep;
            count_d  = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// Registered ARM-subset ALU with an iterative MUL/MLA behind a start/ready/done handshake.
// Single-cycle ops complete in one edge; multiplies hand off to iter_mul.
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_t           state_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;

    logic [WIDTH:0]   sumWide;
    logic [WIDTH:0]   diffWide;
    logic [WIDTH-1:0] aluResult;
    logic             aluCarry;
    logic             aluOverflow;
    logic [3:0]       aluFlags;

    logic             mulLoad;
    logic             mulStep;
    logic [WIDTH-1:0] mulAcc;
    logic             mulLast;
    logic [3:0]       mulFlags;

    assign mulLoad = (state_q == IDLE) && start && isMulOp(op);
    assign mulStep = (state_q == BUSY);

    iter_mul #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .load_i (mulLoad),
        .step_i (mulStep),
        .mla_i  (op == OP_MLA),
        .a_i    (a),
        .b_i    (b),
        .c_i    (c),
        .acc_o  (mulAcc),
        .last_o (mulLast)
    );

    // C on subtract is the inverted borrow, i.e. set when a >= b unsigned.
    always_comb begin
        sumWide     = {1'b0, a} + {1'b0, b};
        diffWide    = {1'b0, a} - {1'b0, b};
        aluResult   = '0;
        aluCarry    = 1'b0;
        aluOverflow = 1'b0;
        case (op)
            OP_ADD: begin
                aluResult   = sumWide[WIDTH-1:0];
                aluCarry    = sumWide[WIDTH];
                aluOverflow = (a[WIDTH-1] == b[WIDTH-1]) && (sumWide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                aluResult   = diffWide[WIDTH-1:0];
                aluCarry    = ~diffWide[WIDTH];
                aluOverflow = (a[WIDTH-1] != b[WIDTH-1]) && (diffWide[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND, OP_TST: aluResult = a & b;
            OP_ORR:         aluResult = a | b;
            OP_EOR:         aluResult = a ^ b;
            OP_MOV:         aluResult = b;
            default:        aluResult = '0;
        endcase
        aluFlags         = 4'b0000;
        aluFlags[FLAG_N] = aluResult[WIDTH-1];
        aluFlags[FLAG_Z] = (aluResult == '0);
        aluFlags[FLAG_C] = aluCarry;
        aluFlags[FLAG_V] = aluOverflow;
    end

    always_comb begin
        mulFlags         = 4'b0000;
        mulFlags[FLAG_N] = mulAcc[WIDTH-1];
        mulFlags[FLAG_Z] = (mulAcc == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (isMulOp(op)) begin
                            state_q <= BUSY;
                            ready_q <= 1'b0;
                        end else begin
                            result_q <= aluResult;
                            flags_q  <= aluFlags;
                            done_q   <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mulLast) begin
                        result_q <= mulAcc;
                        flags_q  <= mulFlags;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu: early-terminating and full-length
// 32-bit instances plus an 8-bit instance, expectations computed by hand.
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, start0, start8;
    logic [3:0]  op;
    logic [31:0] a, b, c;

    logic        ready1, done1;
    logic [31:0] result1;
    logic [3:0]  flags1;
    logic        ready0, done0;
    logic [31:0] result0;
    logic [3:0]  flags0;
    logic        ready8, done8;
    logic [7:0]  result8;
    logic [3:0]  flags8;

    int errors = 0;
    int checks = 0;
    int cycles;
    int lowCycles;
    int doneSeen;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32), .EARLY_TERM(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b), .c(c),
        .ready(ready1), .done(done1), .result(result1), .flags(flags1)
    );

    iter_alu #(.WIDTH(32), .EARLY_TERM(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op), .a(a), .b(b), .c(c),
        .ready(ready0), .done(done0), .result(result0), .flags(flags0)
    );

    iter_alu #(.WIDTH(8), .EARLY_TERM(1)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
        .ready(ready8), .done(done8), .result(result8), .flags(flags8)
    );

    function automatic logic selDone(input int which);
        case (which)
            1:       return done1;
            0:       return done0;
            default: return done8;
        endcase
    endfunction

    function automatic logic selReady(input int which);
        case (which)
            1:       return ready1;
            0:       return ready0;
            default: return ready8;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives one start pulse and returns at the negedge after acceptance.
    task automatic applyStimulus(input int which, input logic [3:0] opv,
                                 input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
        op = opv;
        a  = av;
        b  = bv;
        c  = cv;
        case (which)
            1:       start1 = 1'b1;
            0:       start0 = 1'b1;
            default: start8 = 1'b1;
        endcase
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
        start8 = 1'b0;
    endtask

    // Counts sampled cycles after acceptance up to and including the done cycle.
    task automatic waitDone(input int which, output int n, output int low);
        n   = 1;
        low = 0;
        while (selDone(which) !== 1'b1 && n < 100) begin
            if (selReady(which) === 1'b0) low++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        start8 = 1'b0;
        op     = 4'h0;
        a      = '0;
        b      = '0;
        c      = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(ready1), 32'h1);
        checkOutput("reset_done", 32'(done1), 32'h0);
        checkOutput("reset_result", result1, 32'h0);
        checkOutput("reset_flags", 32'(flags1), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(1, 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0);
        checkOutput("add_ovf_done", 32'(done1), 32'h1);
        checkOutput("add_ovf_result", result1, 32'h8000_0000);
        checkOutput("add_ovf_flags", 32'(flags1), 32'b1001);
        @(negedge clk);
        checkOutput("hold_done", 32'(done1), 32'h0);
        checkOutput("hold_result", result1, 32'h8000_0000);

        applyStimulus(1, 4'b0110, 32'd5, 32'd5, 32'h0);
        checkOutput("cmp_result", result1, 32'h0);
        checkOutput("cmp_flags", 32'(flags1), 32'b0110);
        applyStimulus(1, 4'b0001, 32'd3, 32'd5, 32'h0);
        checkOutput("sub_result", result1, 32'hFFFF_FFFE);
        checkOutput("sub_flags", 32'(flags1), 32'b1000);

        applyStimulus(1, 4'b0010, 32'hF0F0_0000, 32'hFF00_00FF, 32'h0);
        checkOutput("and_result", result1, 32'hF000_0000);
        checkOutput("and_flags", 32'(flags1), 32'b1000);
        applyStimulus(1, 4'b0011, 32'h0F, 32'hF0, 32'h0);
        checkOutput("orr_result", result1, 32'hFF);
        checkOutput("orr_flags", 32'(flags1), 32'b0000);
        applyStimulus(1, 4'b0100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0);
        checkOutput("eor_result", result1, 32'h0);
        checkOutput("eor_flags", 32'(flags1), 32'b0100);
        applyStimulus(1, 4'b0101, 32'h1234, 32'h8000_0001, 32'h0);
        checkOutput("mov_result", result1, 32'h8000_0001);
        checkOutput("mov_flags", 32'(flags1), 32'b1000);
        applyStimulus(1, 4'b0111, 32'h0F, 32'hF0, 32'h0);
        checkOutput("tst_result", result1, 32'h0);
        checkOutput("tst_flags", 32'(flags1), 32'b0100);
        applyStimulus(1, 4'b1100, 32'd5, 32'd7, 32'h0);
        checkOutput("rsv_done", 32'(done1), 32'h1);
        checkOutput("rsv_result", result1, 32'h0);
        checkOutput("rsv_flags", 32'(flags1), 32'b0100);

        applyStimulus(1, 4'b1000, 32'd7, 32'd6, 32'h0);
        waitDone(1, cycles, lowCycles);
        checkOutput("mul_et1_latency", 32'(cycles), 32'd4);
        checkOutput("mul_et1_ready_low", 32'(lowCycles), 32'd3);
        checkOutput("mul_et1_ready_in_done", 32'(ready1), 32'h1);
        checkOutput("mul_et1_result", result1, 32'd42);
        checkOutput("mul_et1_flags", 32'(flags1), 32'b0000);
        applyStimulus(1, 4'b0000, 32'd1, 32'd1, 32'h0);
        checkOutput("b2b_done", 32'(done1), 32'h1);
        checkOutput("b2b_result", result1, 32'd2);

        applyStimulus(1, 4'b1001, 32'hFFFF_FFFF, 32'd2, 32'd3);
        checkOutput("mla_busy_ready", 32'(ready1), 32'h0);
        op     = 4'b0000;
        a      = 32'd100;
        b      = 32'd100;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput("mla_busy_done", 32'(done1), 32'h0);
        @(negedge clk);
        checkOutput("mla_done", 32'(done1), 32'h1);
        checkOutput("mla_result", result1, 32'h1);
        checkOutput("mla_flags", 32'(flags1), 32'b0000);
        @(negedge clk);
        checkOutput("mla_no_extra_done", 32'(done1), 32'h0);

        applyStimulus(1, 4'b1000, 32'h1234, 32'd0, 32'h0);
        waitDone(1, cycles, lowCycles);
        checkOutput("mul_zero_latency", 32'(cycles), 32'd2);
        checkOutput("mul_zero_result", result1, 32'h0);
        checkOutput("mul_zero_flags", 32'(flags1), 32'b0100);

        applyStimulus(0, 4'b1000, 32'd7, 32'd6, 32'h0);
        waitDone(0, cycles, lowCycles);
        checkOutput("mul_et0_latency", 32'(cycles), 32'd33);
        checkOutput("mul_et0_ready_low", 32'(lowCycles), 32'd32);
        checkOutput("mul_et0_result", result0, 32'd42);

        applyStimulus(0, 4'b1000, 32'd3, 32'd5, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("abort_busy_ready", 32'(ready0), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", 32'(ready0), 32'h1);
        checkOutput("abort_done", 32'(done0), 32'h0);
        checkOutput("abort_result", result0, 32'h0);
        checkOutput("abort_flags", 32'(flags0), 32'h0);
        reset    = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) doneSeen++;
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'd0);

        applyStimulus(8, 4'b0000, 32'hFF, 32'h01, 32'h0);
        checkOutput("w8_add_done", 32'(done8), 32'h1);
        checkOutput("w8_add_result", 32'(result8), 32'h0);
        checkOutput("w8_add_flags", 32'(flags8), 32'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_alu.md
# iter_alu

Parametrised ARM-subset execution unit, the next generation of the processor's combinational ALU. It keeps the data-processing operations ADD, SUB, AND, ORR, EOR, MOV, CMP and TST and adds iterative shift-add MUL/MLA. A start/ready/done handshake lets the core stall while a multiply runs. Results and flags are registered, so the unit sits between the register-file read ports and writeback in the multicycle datapath.

## Interface
- WIDTH, 32, operand/result width in bits (≥4)
- EARLY_TERM, 1, when 1 a multiply ends as soon as the remaining multiplier is zero
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  request; accepted on a rising edge when ready=1
- op  in  4  operation code (alu_op_t)
- a, b  in  WIDTH  operands; b is the multiplier for MUL/MLA
- c  in  WIDTH  accumulate addend (MLA only)
- ready  out  1  unit idle, can accept start
- done  out  1  one-cycle pulse: result/flags valid and updated
- result  out  WIDTH  registered result
- flags  out  4  registered {N,Z,C,V}
- One clock; reset is synchronous and active-high.

## Operation
- op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV, 0110 CMP, 0111 TST, 1000 MUL, 1001 MLA, 1010–1111 reserved.
- ADD/SUB/CMP:
  - result = a±b mod 2^WIDTH.
  - C for ADD = carry out of bit WIDTH-1.
  - C for SUB/CMP = no-borrow (a ≥ b unsigned).
  - V = signed overflow.
  - CMP drives result; writeback suppression is the controller's job.
- AND/ORR/EOR/TST/MOV: MOV passes b; TST = a&b. N,Z from result; C=V=0.
- MUL: result = (a·b) mod 2^WIDTH.
- MLA: result = (a·b + c) mod 2^WIDTH.
- MUL/MLA flags: N,Z from result; C=V=0.
- Reserved ops: result=0, flags=0100, same timing as single-cycle ops.
- FSM states IDLE and BUSY; ready = (state==IDLE).
  - IDLE, start, non-multiply: compute and register, assert done, stay IDLE.
  - IDLE, start, MUL/MLA: go to BUSY and load the multiplier datapath:
    - mcand = a
    - mplier = b
    - acc = (MLA ? c : 0)
    - iteration count = 0
  - BUSY, each edge, one iteration:
    - if mplier[0], acc += mcand
    - mcand <<= 1
    - mplier >>= 1
    - count++
  - BUSY, last iteration: register acc, assert done, go to IDLE.
- Last iteration:
  - EARLY_TERM=0: count reaches WIDTH.
  - EARLY_TERM=1: either count reaches WIDTH, or (mplier>>1)==0 at the end of the current iteration.
- start while BUSY is ignored; inputs are not sampled.
- result/flags hold their value between done pulses.

## Timing
- Reset values: state IDLE, ready=1, done=0, result=0, flags=0000; multiplier registers cleared.
- Reset while BUSY aborts the multiply: no done, ready=1 in the cycle after the reset edge.
- Non-multiply op: accepted at edge E0; done=1 with valid result during the cycle after E0 (latency 1).
- MUL/MLA latency is k+1 edges, with iterations at edges E1..Ek and done after Ek.
  - EARLY_TERM=0: k = WIDTH.
  - EARLY_TERM=1: k = max(1, index of highest set bit of b + 1).
- ready is low from after E0 through Ek. In the done cycle ready=1, so a back-to-back start is accepted.
- done never stays high for two consecutive cycles unless back-to-back ops are accepted.

## Structure
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_t with the codes above
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - typedef enum state_t {IDLE, BUSY}
- One sub-module, iter_mul (WIDTH, EARLY_TERM): the shift-add datapath, iteration counter and last-iteration detect, with load/step/last signals.
- Top level: op decode, single-cycle ALU, FSM, result/flag registers.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → done next cycle, result 0x80000000, flags 1001.
- CMP a=5, b=5 → result 0, flags 0110; then SUB a=3, b=5 → 0xFFFFFFFE, flags 1000.
- MUL a=7, b=6 with EARLY_TERM=1 → ready low 3 cycles, done on 4th cycle after accept, result 42, flags 0000. Same with EARLY_TERM=0 → done 33 cycles after accept.
- MLA a=0xFFFFFFFF, b=2, c=3 → result 0x00000001, flags 0000; start pulses during BUSY have no effect.
- Back-to-back: ADD 1+1 issued in the MUL done cycle → accepted, done again the next cycle with result 2.
- Reset at 5th multiply iteration → no done, ready=1 next cycle, result 0. A WIDTH=8 instance doing ADD 0xFF+0x01 → result 0x00, flags 0110.
